mc_queue: RTL and testbench

- Single-clock, multi-channel queue: C independent FIFOs of depth N share one W-bit storage array, partitioned per channel.
- Successor to the single-channel queue. Adds channel select, per-channel occupancy, almost-full watermark, per-channel flush and sticky overflow/underflow error flags.
- Sits between a multi-source producer (e.g. per-VC request streams) and an arbitrating consumer in the same clock domain.

---
 rtl/mc_queue_pkg.sv | 12 +
 rtl/mc_queue_chan_ctl.sv | 61 ++++++
 rtl/mc_queue.sv | 78 +++++++
 tb/tb_mc_queue.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mc_queue_pkg.sv
// Shared width helpers for the multi-channel queue and its bench.
package mc_queue_pkg;

    function automatic int ch_w(input int c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mc_queue_chan_ctl.sv
// One channel's pointer pair, accept logic, flush and occupancy flags.
module mc_queue_chan_ctl
    import mc_queue_pkg::*;
#(
    parameter int N  = 16,
    parameter int AF = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    output logic [$clog2(N)-1:0]  waddr,
    output logic [$clog2(N)-1:0]  raddr,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic [cnt_w(N)-1:0]   cnt,
    output logic                  push_ok,
    output logic                  pop_ok,
    output logic                  ovf,
    output logic                  udf
);
    localparam int AW   = $clog2(N);
    localparam int CNTW = cnt_w(N);

    // x is the wrap bit; a carry out of a lands in x, so {x,a}+1 wraps cleanly.
    typedef struct packed {
        logic          x;
        logic [AW-1:0] a;
    } ptr_t;

    ptr_t wptr;
    ptr_t rptr;

    assign waddr = wptr.a;
    assign raddr = rptr.a;
    assign empty = (wptr == rptr);
    assign full  = (wptr.x != rptr.x) && (wptr.a == rptr.a);
    assign cnt   = wptr - rptr;
    assign afull = (cnt >= CNTW'(AF));

    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign ovf     = push & full & ~flush;
    assign udf     = pop & empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (flush)
                rptr <= wptr;
            else if (pop_ok)
                rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/mc_queue.sv
// C independent FIFOs sharing one storage array, with per-channel flags and sticky errors.
module mc_queue
    import mc_queue_pkg::*;
#(
    parameter int W  = 32,
    parameter int N  = 16,
    parameter int C  = 4,
    parameter int AF = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [ch_w(C)-1:0]        push_ch,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    input  logic [ch_w(C)-1:0]        pop_ch,
    output logic [W-1:0]              pop_data,
    input  logic [C-1:0]              flush,
    output logic [C-1:0]              empty_w,
    output logic [C-1:0]              full_w,
    output logic [C-1:0]              afull_w,
    output logic [C*cnt_w(N)-1:0]     cnt_r,
    output logic                      err_ovf_r,
    output logic                      err_udf_r
);
    localparam int AW   = $clog2(N);
    localparam int CW   = ch_w(C);
    localparam int CNTW = cnt_w(N);

    // Handshake: push is taken at the edge when the target channel is neither
    // full nor flushed; pop likewise when not empty nor flushed. No ready is
    // returned -- refused requests are dropped and raise the sticky error flags
    // (except when refused because of a flush). pop_data is show-ahead.
    logic [W-1:0]  mem [C][N];
    logic [AW-1:0] waddr [C];
    logic [AW-1:0] raddr [C];
    logic [C-1:0]  push_ok;
    logic [C-1:0]  pop_ok;
    logic [C-1:0]  ovf;
    logic [C-1:0]  udf;

    for (genvar c = 0; c < C; c++) begin : g_chan
        mc_queue_chan_ctl #(.N(N), .AF(AF)) u_ctl (
            .clk     (clk),
            .rst     (rst),
            .push    (push && (push_ch == CW'(c))),
            .pop     (pop && (pop_ch == CW'(c))),
            .flush   (flush[c]),
            .waddr   (waddr[c]),
            .raddr   (raddr[c]),
            .empty   (empty_w[c]),
            .full    (full_w[c]),
            .afull   (afull_w[c]),
            .cnt     (cnt_r[c*CNTW +: CNTW]),
            .push_ok (push_ok[c]),
            .pop_ok  (pop_ok[c]),
            .ovf     (ovf[c]),
            .udf     (udf[c])
        );
    end

    always_ff @(posedge clk) begin
        if (|push_ok) mem[push_ch][waddr[push_ch]] <= push_data;
    end

    assign pop_data = mem[pop_ch][raddr[pop_ch]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_r <= 1'b0;
            err_udf_r <= 1'b0;
        end else begin
            err_ovf_r <= err_ovf_r | (|ovf);
            err_udf_r <= err_udf_r | (|udf);
        end
    end

endmodule

// File: tb/tb_mc_queue.sv
// Scoreboard bench for mc_queue: per-channel expected queues drive all checks.
module tb_mc_queue;
    import mc_queue_pkg::*;

    localparam int W    = 32;
    localparam int N    = 16;
    localparam int C    = 4;
    localparam int AF   = 14;
    localparam int CW   = ch_w(C);
    localparam int CNTW = cnt_w(N);

    logic                  clk;
    logic                  rst;
    logic                  push;
    logic [CW-1:0]         push_ch;
    logic [W-1:0]          push_data;
    logic                  pop;
    logic [CW-1:0]         pop_ch;
    logic [W-1:0]          pop_data;
    logic [C-1:0]          flush;
    logic [C-1:0]          empty_w;
    logic [C-1:0]          full_w;
    logic [C-1:0]          afull_w;
    logic [C*CNTW-1:0]     cnt_r;
    logic                  err_ovf_r;
    logic                  err_udf_r;

    mc_queue #(.W(W), .N(N), .C(C), .AF(AF)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_ch   (push_ch),
        .push_data (push_data),
        .pop       (pop),
        .pop_ch    (pop_ch),
        .pop_data  (pop_data),
        .flush     (flush),
        .empty_w   (empty_w),
        .full_w    (full_w),
        .afull_w   (afull_w),
        .cnt_r     (cnt_r),
        .err_ovf_r (err_ovf_r),
        .err_udf_r (err_udf_r)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q [C][$];
    logic         m_ovf;
    logic         m_udf;
    int           n_checks;
    int           n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_state(input string tag);
        for (int c = 0; c < C; c++) begin
            int sz;
            sz = exp_q[c].size();
            check($sformatf("%s cnt ch%0d", tag, c), 64'(cnt_r[c*CNTW +: CNTW]), 64'(sz));
            check($sformatf("%s empty ch%0d", tag, c), 64'(empty_w[c]), 64'(sz == 0));
            check($sformatf("%s full ch%0d", tag, c), 64'(full_w[c]), 64'(sz == N));
            check($sformatf("%s afull ch%0d", tag, c), 64'(afull_w[c]), 64'(sz >= AF));
        end
        check({tag, " err_ovf"}, 64'(err_ovf_r), 64'(m_ovf));
        check({tag, " err_udf"}, 64'(err_udf_r), 64'(m_udf));
    endtask

    // ---------------- driver ----------------
    // Called #1 after a rising edge; drives one cycle of stimulus and updates the model.
    task automatic step(input bit ps, input int pch, input logic [W-1:0] pd,
                        input bit pp, input int qch, input logic [C-1:0] fl,
                        input bit chk = 1'b1);
        bit pacc;
        bit qacc;
        push = ps; push_ch = CW'(pch); push_data = pd;
        pop = pp; pop_ch = CW'(qch); flush = fl;
        pacc = ps && !fl[pch] && (exp_q[pch].size() < N);
        qacc = pp && !fl[qch] && (exp_q[qch].size() > 0);
        if (ps && !fl[pch] && exp_q[pch].size() == N) m_ovf = 1'b1;
        if (pp && !fl[qch] && exp_q[qch].size() == 0) m_udf = 1'b1;
        #1;
        if (qacc) check($sformatf("pop_data ch%0d", qch), 64'(pop_data), 64'(exp_q[qch][0]));
        @(posedge clk);
        #1;
        for (int c = 0; c < C; c++) if (fl[c]) exp_q[c].delete();
        if (qacc) void'(exp_q[qch].pop_front());
        if (pacc) exp_q[pch].push_back(pd);
        push = 1'b0; pop = 1'b0; flush = '0;
        if (chk) check_state("step");
    endtask

    task automatic do_push(input int ch, input logic [W-1:0] d);
        step(1'b1, ch, d, 1'b0, 0, '0);
    endtask

    task automatic do_pop(input int ch);
        step(1'b0, 0, '0, 1'b1, ch, '0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_checks = 0; n_pass = 0;
        m_ovf = 1'b0; m_udf = 1'b0;
        rst = 1'b1;
        push = 1'b0; push_ch = '0; push_data = '0;
        pop = 1'b0; pop_ch = '0; flush = '0;
        #1;
        check_state("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("post_reset");

        // Basic order on ch2
        for (int i = 0; i < 4; i++) do_push(2, W'(32'hA0 + i));
        check("ch2 cnt4", 64'(cnt_r[2*CNTW +: CNTW]), 64'd4);
        for (int i = 0; i < 4; i++) do_pop(2);

        // Fill ch1, watermark, overflow, drain
        for (int i = 0; i < N; i++) begin
            do_push(1, W'(32'h100 + i));
            if (i == AF - 2) check("afull before AF", 64'(afull_w[1]), 64'd0);
            if (i == AF - 1) check("afull at AF", 64'(afull_w[1]), 64'd1);
        end
        check("ch1 full", 64'(full_w[1]), 64'd1);
        do_push(1, 32'hDEAD_BEEF);
        check("ovf set", 64'(err_ovf_r), 64'd1);
        for (int i = 0; i < N; i++) do_pop(1);

        // Underflow with concurrent push on ch3
        step(1'b1, 3, 32'h0000_00C3, 1'b1, 3, '0);
        check("udf set", 64'(err_udf_r), 64'd1);
        pop_ch = CW'(3);
        #1;
        check("ch3 peek", 64'(pop_data), 64'h0000_00C3);
        do_pop(3);

        // Full ch0 with simultaneous push/pop, then cross-channel push/pop
        for (int i = 0; i < N; i++) do_push(0, W'(32'h200 + i));
        step(1'b1, 0, 32'hBAD0_0000, 1'b1, 0, '0);
        check("ch0 cnt 15", 64'(cnt_r[0 +: CNTW]), 64'd15);
        do_push(1, 32'h0000_0111);
        step(1'b1, 0, 32'h0000_0300, 1'b1, 1, '0);
        while (exp_q[0].size() > 3) do_pop(0);

        // Wrap ch0 holding 3 entries
        for (int i = 0; i < 40; i++) step(1'b1, 0, $urandom, 1'b1, 0, '0);
        while (exp_q[0].size() > 0) do_pop(0);

        // Flush ch2 holding 5, with concurrent push to ch2
        for (int i = 0; i < 5; i++) do_push(2, W'(32'h500 + i));
        step(1'b1, 2, 32'h0000_0555, 1'b0, 0, 4'b0100);
        check("flush empty", 64'(empty_w[2]), 64'd1);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, C - 1)), $urandom,
                 1'($urandom_range(0, 2) != 0), int'($urandom_range(0, C - 1)),
                 ($urandom_range(0, 19) == 0) ? C'(1 << $urandom_range(0, C - 1)) : '0,
                 1'((i % 10) == 0));
        check_state("random end");

        // Async reset mid-stream
        for (int i = 0; i < 3; i++) do_push(1, W'(32'h700 + i));
        push = 1'b1; push_ch = CW'(1); push_data = 32'h0000_0777;
        #1;
        rst = 1'b1;
        #1;
        for (int c = 0; c < C; c++) exp_q[c].delete();
        m_ovf = 1'b0; m_udf = 1'b0;
        check_state("async_reset");
        push = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("after_reset");
        do_push(3, 32'h0000_0900);
        do_pop(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
